// File: rtl/seg_scan_capture_if.sv
// rtl/seg_scan_capture_if.sv - scanned seven-segment bus (digit enables and segment lines)
interface seg_scan_capture_if;
    logic [7:0] seg_en;
    logic [7:0] seg_out;

    modport master (
        output seg_en,
        output seg_out
    );

    modport slave (
        input seg_en,
        input seg_out
    );
endinterface

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - recovers 8-digit BCD frames from a scanned seven-segment bus
module seg_scan_capture #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_capture_if.slave   scan,
    input  logic                err_clr,
    output logic [31:0]         digits,
    output logic                frame_done,
    output logic                decode_err,
    output logic                enable_err,
    output logic                frame_lost
);
    localparam int CW = 16;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    // {en[7:0], seg[6:0]}; dp is dropped before the synchronizer so it cannot break stability
    logic [14:0]   sync_q [SYNC_STAGES];
    logic [14:0]   prev_q;
    logic [14:0]   cur;
    logic [7:0]    en;
    logic [6:0]    seg;
    logic          dp_unused;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          done_q;
    logic          same;
    logic          capture;

    logic [3:0]    zero_cnt;
    logic [2:0]    zero_idx;
    logic [4:0]    dec;
    logic          cap_legal;
    logic          cap_bad_seg;
    logic          cap_bad_en;

    logic [31:0]   shadow_q;
    logic [7:0]    seen_q;
    logic [7:0]    seen_nxt;
    logic [TW-1:0] tcnt_q;

    // Returns {valid, value}; the blank pattern decodes to 4'hF.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   return 5'h10;
            7'h79:   return 5'h11;
            7'h24:   return 5'h12;
            7'h30:   return 5'h13;
            7'h19:   return 5'h14;
            7'h12:   return 5'h15;
            7'h02:   return 5'h16;
            7'h78:   return 5'h17;
            7'h00:   return 5'h18;
            7'h10:   return 5'h19;
            7'h7F:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    assign dp_unused = scan.seg_out[7];
    assign cur       = sync_q[SYNC_STAGES-1];
    assign en        = cur[14:7];
    assign seg       = cur[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= {scan.seg_en, scan.seg_out[6:0]};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        same    = (cur == prev_q);
        cnt_nxt = '0;
        if (same) begin
            cnt_nxt = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        // fire on the cycle the window completes, once per window
        capture = same && (cnt_nxt == STABLE_MAX) && !done_q;
    end

    always_comb begin
        zero_cnt = '0;
        zero_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!en[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                zero_idx = 3'(i);
            end
        end
        dec         = seg_decode(seg);
        cap_legal   = capture && (zero_cnt == 4'd1) && dec[4];
        cap_bad_seg = capture && (zero_cnt == 4'd1) && !dec[4];
        cap_bad_en  = capture && (zero_cnt > 4'd1);
    end

    always_comb begin
        seen_nxt = (seen_q == 8'hFF) ? 8'h00 : seen_q;
        if (cap_legal) begin
            seen_nxt[zero_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '1;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            shadow_q   <= '1;
            seen_q     <= '0;
            tcnt_q     <= '0;
            digits     <= '1;
            frame_done <= 1'b0;
            decode_err <= 1'b0;
            enable_err <= 1'b0;
        end else begin
            prev_q <= cur;
            cnt_q  <= cnt_nxt;
            if (!same) begin
                done_q <= 1'b0;
            end else if (capture) begin
                done_q <= 1'b1;
            end

            if (cap_legal) begin
                shadow_q[{zero_idx, 2'b00} +: 4] <= dec[3:0];
            end
            seen_q <= seen_nxt;

            frame_done <= (seen_q == 8'hFF);
            if (seen_q == 8'hFF) begin
                digits <= shadow_q;
            end

            if (cap_legal) begin
                tcnt_q <= '0;
            end else if (tcnt_q != TIMEOUT_MAX) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            // a new error in the same cycle as err_clr wins
            decode_err <= (decode_err & ~err_clr) | cap_bad_seg;
            enable_err <= (enable_err & ~err_clr) | cap_bad_en;
        end
    end

    assign frame_lost = (tcnt_q == TIMEOUT_MAX);
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - randomized and directed bench for seg_scan_capture
module tb_seg_scan_capture;
    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int TMO    = 1000;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] digits;
    logic        frame_done;
    logic        decode_err;
    logic        enable_err;
    logic        frame_lost;

    int n_vec    = 0;
    int n_bad    = 0;
    int fd_count = 0;

    logic [6:0] seg_code [0:10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                    7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

    seg_scan_capture_if scan();

    seg_scan_capture #(
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan       (scan),
        .err_clr    (err_clr),
        .digits     (digits),
        .frame_done (frame_done),
        .decode_err (decode_err),
        .enable_err (enable_err),
        .frame_lost (frame_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a value is captured once its run of identical samples
    // reaches STABLE+1, and takes effect SYNC cycles later.
    typedef struct {
        bit         v;
        logic [7:0] en;
        logic [6:0] seg;
    } ev_t;

    ev_t         dq[$];
    ev_t         ev_in;
    ev_t         ev_out;
    logic [14:0] last_x = '1;
    logic [14:0] x;
    int          run    = 0;
    logic [3:0]  m_shadow [8];
    logic [7:0]  m_seen   = '0;
    logic [31:0] m_digits = '1;
    logic        m_fd     = 1'b0;
    logic        m_derr   = 1'b0;
    logic        m_eerr   = 1'b0;
    int          m_tcnt   = 0;
    int          m_val;
    int          m_idx;
    bit          m_legal;
    bit          m_bad_seg;
    bit          m_bad_en;

    function automatic int model_decode(input logic [6:0] s);
        for (int i = 0; i <= 10; i++) begin
            if (seg_code[i] == s) return (i == 10) ? 15 : i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq.delete();
            run      = 0;
            last_x   = '1;
            m_seen   = '0;
            m_digits = '1;
            m_fd     = 1'b0;
            m_derr   = 1'b0;
            m_eerr   = 1'b0;
            m_tcnt   = 0;
            for (int i = 0; i < 8; i++) m_shadow[i] = 4'hF;
        end else begin
            x = {scan.seg_en, scan.seg_out[6:0]};
            run = (x == last_x) ? run + 1 : 1;
            last_x = x;
            ev_in.v   = (run == STABLE + 1);
            ev_in.en  = x[14:7];
            ev_in.seg = x[6:0];
            dq.push_back(ev_in);
            ev_out.v = 1'b0;
            if (dq.size() > SYNC) ev_out = dq.pop_front();

            m_fd = 1'b0;
            if (m_seen == 8'hFF) begin
                for (int i = 0; i < 8; i++) m_digits[4*i +: 4] = m_shadow[i];
                m_fd   = 1'b1;
                m_seen = '0;
            end

            m_legal   = 0;
            m_bad_seg = 0;
            m_bad_en  = 0;
            if (ev_out.v) begin
                if ($countones(~ev_out.en) == 1) begin
                    m_idx = 0;
                    for (int i = 0; i < 8; i++) if (!ev_out.en[i]) m_idx = i;
                    m_val = model_decode(ev_out.seg);
                    if (m_val >= 0) begin
                        m_shadow[m_idx] = 4'(m_val);
                        m_seen[m_idx]   = 1'b1;
                        m_legal         = 1;
                    end else begin
                        m_bad_seg = 1;
                    end
                end else if ($countones(~ev_out.en) > 1) begin
                    m_bad_en = 1;
                end
            end
            m_tcnt = m_legal ? 0 : ((m_tcnt < TMO) ? m_tcnt + 1 : TMO);
            m_derr = (m_derr && !err_clr) || m_bad_seg;
            m_eerr = (m_eerr && !err_clr) || m_bad_en;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("digits", digits, m_digits);
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("decode_err", 32'(decode_err), 32'(m_derr));
            chk("enable_err", 32'(enable_err), 32'(m_eerr));
            chk("frame_lost", 32'(frame_lost), 32'(m_tcnt == TMO));
            if (frame_done) fd_count++;
        end
    end

    task automatic hold(input logic [7:0] en, input logic [6:0] seg, input int len,
                        input int dp_mode, input bit clr);
        logic dp;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            dp = (dp_mode == 0) ? 1'b1 : (dp_mode == 1) ? k[0] : 1'($urandom);
            scan.seg_en  = en;
            scan.seg_out = {dp, seg};
            err_clr      = clr && (k == 0);
        end
    endtask

    task automatic idle(input int len, input bit clr);
        hold(8'hFF, 7'h7F, len, 0, clr);
    endtask

    task automatic send_digit(input int i, input int code, input int len, input int dp_mode);
        logic [7:0] en;
        en = ~(8'b1 << i);
        hold(en, seg_code[code], len, dp_mode, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    int fd0;
    int a;
    int b;
    int r;
    logic [7:0] ren;
    logic [6:0] rseg;

    initial begin
        scan.seg_en  = '1;
        scan.seg_out = '1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(5, 0);
        #1;
        chk("reset_digits", digits, 32'hFFFF_FFFF);
        chk("reset_flags", {28'h0, frame_done, decode_err, enable_err, frame_lost}, 32'h0);

        // "12345678": digit i shows 8-i
        fd0 = fd_count;
        for (int i = 0; i < 8; i++) send_digit(i, 8 - i, 40, 0);
        idle(10, 0);
        #1;
        chk("p1_frames", fd_count - fd0, 1);
        chk("p1_digits", digits, 32'h1234_5678);
        chk("p1_model", m_digits, 32'h1234_5678);
        chk("p1_errs", {30'h0, decode_err, enable_err}, 32'h0);

        // digits held shorter than the stability window never land
        fd0 = fd_count;
        for (int n = 0; n < 15; n++)
            for (int i = 0; i < 8; i++) send_digit(i, 0, 10, 0);
        #1;
        chk("p2_lost", 32'(frame_lost), 32'h1);
        chk("p2_frames", fd_count - fd0, 0);
        chk("p2_digits", digits, 32'h1234_5678);

        // illegal pattern on digit 3 blocks the frame until a legal one arrives
        fd0 = fd_count;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) hold(8'b1111_0111, 7'h55, 40, 0, 1'b0);
            else        send_digit(i, i + 1, 40, 0);
        end
        idle(10, 0);
        #1;
        chk("p3_decode_err", 32'(decode_err), 32'h1);
        chk("p3_no_frame", fd_count - fd0, 0);
        chk("p3_lost_clear", 32'(frame_lost), 32'h0);
        idle(5, 1);
        #1;
        chk("p3_err_clr", 32'(decode_err), 32'h0);
        send_digit(3, 4, 40, 0);
        idle(10, 0);
        #1;
        chk("p3_frames", fd_count - fd0, 1);
        chk("p3_digits", digits, 32'h8765_4321);

        // two digits enabled at once
        hold(8'b1111_0011, seg_code[5], 20, 0, 1'b0);
        idle(10, 0);
        #1;
        chk("p4_enable_err", 32'(enable_err), 32'h1);
        chk("p4_digits", digits, 32'h8765_4321);
        idle(5, 1);
        #1;
        chk("p4_err_clr", 32'(enable_err), 32'h0);

        // blank frame with dp toggling every cycle
        fd0 = fd_count;
        for (int i = 0; i < 8; i++) send_digit(i, 10, 40, 1);
        idle(10, 0);
        #1;
        chk("p5_frames", fd_count - fd0, 1);
        chk("p5_digits", digits, 32'hFFFF_FFFF);

        // reset mid-frame, then a fresh frame
        for (int i = 0; i < 5; i++) send_digit(i, i + 1, 40, 0);
        idle(5, 0);
        pulse_reset();
        idle(5, 0);
        #1;
        chk("p6_reset_digits", digits, 32'hFFFF_FFFF);
        fd0 = fd_count;
        for (int i = 0; i < 7; i++) send_digit(i, (i + 9) % 10, 40, 0);
        #1;
        chk("p6_no_early_frame", fd_count - fd0, 0);
        send_digit(7, 6, 40, 0);
        idle(10, 0);
        #1;
        chk("p6_frames", fd_count - fd0, 1);
        chk("p6_digits", digits, 32'h6543_2109);

        // randomized scan traffic, checked cycle by cycle against the model
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 7);
            if (r < 6) begin
                ren = 8'hFF;
            end else if (r < 14) begin
                b   = (a + $urandom_range(1, 7)) % 8;
                ren = ~((8'b1 << a) | (8'b1 << b));
            end else begin
                ren = ~(8'b1 << a);
            end
            rseg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : seg_code[$urandom_range(0, 10)];
            hold(ren, rseg, $urandom_range(5, 30), 2, $urandom_range(0, 39) == 0);
        end
        idle(30, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
